// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / flush / bubble control for the 5-stage MIPS pipeline.
// Detects load-use hazards, ID-resolved branches/jumps and data-memory wait
// states; a memory access stuck for MEM_TIMEOUT cycles latches a sticky error.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ifid_rsaddr_i,
  input  logic [4:0]  ifid_rtaddr_i,
  input  logic        ifid_uses_rt_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rtaddr_i,
  input  logic        branch_taken_i,
  input  logic        jump_i,
  input  logic        exmem_memreq_i,
  input  logic        dmem_ack_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        stall_all_o,
  output logic        mem_err_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

  // wcnt holds the number of stalled cycles already elapsed, so the timeout
  // edge is the one ending stall cycle MEM_TIMEOUT.
  localparam logic [7:0] WCNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nx;
  logic [7:0] wcnt, wcnt_nx;
  logic       memstall, loaduse, redirect;

  assign memstall = exmem_memreq_i & ~dmem_ack_i;
  assign loaduse  = idex_memread_i & (idex_rtaddr_i != 5'd0) &
                    ((idex_rtaddr_i == ifid_rsaddr_i) |
                     (ifid_uses_rt_i & (idex_rtaddr_i == ifid_rtaddr_i)));
  assign redirect = branch_taken_i | jump_i;

  // State and wait-counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= RUN;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  // Next-state: enter WAIT on a memory stall, leave on ack, escalate on timeout.
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    case (state)
      RUN: begin
        if (memstall) begin
          if (wcnt == WCNT_LAST) begin
            state_nx = ERR;
          end else begin
            state_nx = WAIT;
            wcnt_nx  = wcnt + 8'd1;
          end
        end
      end
      WAIT: begin
        if (dmem_ack_i) begin
          state_nx = RUN;
          wcnt_nx  = '0;
        end else if (wcnt == WCNT_LAST) begin
          state_nx = ERR;
        end else begin
          wcnt_nx = wcnt + 8'd1;
        end
      end
      ERR:     state_nx = ERR;
      default: begin
        state_nx = RUN;
        wcnt_nx  = '0;
      end
    endcase
  end

  // Pipeline controls, priority ERR > memstall > load-use > redirect.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    stall_all_o   = 1'b0;
    mem_err_o     = 1'b0;
    if (!rst_i) begin
      pc_write_o    = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (state == ERR) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      stall_all_o  = 1'b1;
      mem_err_o    = 1'b1;
    end else if (memstall) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      stall_all_o  = 1'b1;
    end else if (loaduse) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (redirect) begin
      ifid_flush_o = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;

  // Perf counters: cycles with PC held, cycles with IF/ID flushed.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write_o)  stall_cnt <= stall_cnt + 32'd1;
      if (ifid_flush_o) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MEM_TIMEOUT = 4).
// Stimulus vector layout: {rs[20:16], rt[15:11], uses_rt[10], memread[9],
// idex_rt[8:4], branch[3], jump[2], memreq[1], ack[0]}.
// Expected output vector: {pc_write, ifid_write, ifid_flush, idex_bubble,
// stall_all, mem_err}.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [4:0]  ifid_rsaddr_i, ifid_rtaddr_i, idex_rtaddr_i;
  logic        ifid_uses_rt_i, idex_memread_i, branch_taken_i, jump_i;
  logic        exmem_memreq_i, dmem_ack_i;
  logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o;
  logic        stall_all_o, mem_err_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;
  logic [5:0]  outs;

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] exp_q[$];

  localparam logic [5:0] O_NORM  = 6'b110000;
  localparam logic [5:0] O_LU    = 6'b000100;
  localparam logic [5:0] O_RED   = 6'b111000;
  localparam logic [5:0] O_MEM   = 6'b000010;
  localparam logic [5:0] O_ERR   = 6'b000011;
  localparam logic [5:0] O_RST   = 6'b011100;
  localparam logic [20:0] IDLE   = '0;

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ifid_rsaddr_i(ifid_rsaddr_i), .ifid_rtaddr_i(ifid_rtaddr_i),
    .ifid_uses_rt_i(ifid_uses_rt_i), .idex_memread_i(idex_memread_i),
    .idex_rtaddr_i(idex_rtaddr_i), .branch_taken_i(branch_taken_i),
    .jump_i(jump_i), .exmem_memreq_i(exmem_memreq_i), .dmem_ack_i(dmem_ack_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .ifid_flush_o(ifid_flush_o), .idex_bubble_o(idex_bubble_o),
    .stall_all_o(stall_all_o), .mem_err_o(mem_err_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  assign outs = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
                 stall_all_o, mem_err_o};

  function automatic logic [20:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic urt, input logic mr,
                                     input logic [4:0] xrt, input logic br,
                                     input logic jp, input logic mq,
                                     input logic ak);
    return {rs, rt, urt, mr, xrt, br, jp, mq, ak};
  endfunction

  task automatic set_in(input logic [20:0] v);
    {ifid_rsaddr_i, ifid_rtaddr_i, ifid_uses_rt_i, idex_memread_i,
     idex_rtaddr_i, branch_taken_i, jump_i, exmem_memreq_i, dmem_ack_i} = v;
  endtask

  // Drive one cycle's inputs just after the rising edge and queue the expectation.
  task automatic apply(input logic [20:0] v, input logic [5:0] e);
    @(posedge clk);
    #1;
    set_in(v);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    set_in(IDLE);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] e;
    rst_i = 1'b0;
    set_in(IDLE);
    #2;
    exp_q.push_back(O_RST);
    e = exp_q.pop_front();
    n_tests++;
    if (outs !== e) begin
      n_fail++;
      $display("FAIL reset_outs got=%b exp=%b", outs, e);
    end
    n_tests++;
    if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o);
    end
    @(posedge clk);
    #1;
    rst_i = 1'b1;
  endtask

  task automatic test_load_use();
    logic [20:0] st[6];
    logic [5:0]  ev[6];
    logic [5:0]  e;
    st[0] = mk(5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0); ev[0] = O_LU;
    st[1] = mk(5'd8, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); ev[1] = O_NORM;
    st[2] = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); ev[2] = O_NORM;
    st[3] = mk(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0); ev[3] = O_LU;
    st[4] = mk(5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0); ev[4] = O_NORM;
    st[5] = mk(5'd7, 5'd9, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0); ev[5] = O_NORM;
    for (int i = 0; i < 6; i++) begin
      apply(st[i], ev[i]);
      e = exp_q.pop_front();
      n_tests++;
      if (outs !== e) begin
        n_fail++;
        $display("FAIL load_use[%0d] got=%b exp=%b", i, outs, e);
      end
    end
  endtask

  task automatic test_branch();
    logic [20:0] st[5];
    logic [5:0]  ev[5];
    logic [5:0]  e;
    st[0] = mk(5'd2, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); ev[0] = O_RED;
    st[1] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); ev[1] = O_RED;
    st[2] = mk(5'd8, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0); ev[2] = O_LU;
    st[3] = mk(5'd8, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); ev[3] = O_RED;
    st[4] = IDLE;                                                       ev[4] = O_NORM;
    for (int i = 0; i < 5; i++) begin
      apply(st[i], ev[i]);
      e = exp_q.pop_front();
      n_tests++;
      if (outs !== e) begin
        n_fail++;
        $display("FAIL branch[%0d] got=%b exp=%b", i, outs, e);
      end
    end
  endtask

  // Two 3-cycle waits back to back; the 4th-cycle ack also hits the timeout
  // boundary, and a stale wait count would push the second wait into ERR.
  task automatic test_back_to_back();
    logic [20:0] st[11];
    logic [5:0]  ev[11];
    logic [20:0] ms, ma, lu;
    logic [5:0]  e;
    ms = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    ma = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    lu = mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    st[0] = ma;   ev[0] = O_NORM;
    st[1] = ms;   ev[1] = O_MEM;
    st[2] = lu;   ev[2] = O_MEM;
    st[3] = ms;   ev[3] = O_MEM;
    st[4] = ma;   ev[4] = O_NORM;
    st[5] = ms;   ev[5] = O_MEM;
    st[6] = ms;   ev[6] = O_MEM;
    st[7] = ms;   ev[7] = O_MEM;
    st[8] = ma;   ev[8] = O_NORM;
    st[9] = IDLE; ev[9] = O_NORM;
    st[10] = IDLE; ev[10] = O_NORM;
    for (int i = 0; i < 11; i++) begin
      apply(st[i], ev[i]);
      e = exp_q.pop_front();
      n_tests++;
      if (outs !== e) begin
        n_fail++;
        $display("FAIL mem_wait[%0d] got=%b exp=%b", i, outs, e);
      end
    end
  endtask

  task automatic test_jump_memstall();
    logic [20:0] st[4];
    logic [5:0]  ev[4];
    logic [5:0]  e;
    st[0] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0); ev[0] = O_MEM;
    st[1] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0); ev[1] = O_MEM;
    st[2] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1); ev[2] = O_RED;
    st[3] = IDLE;                                                       ev[3] = O_NORM;
    for (int i = 0; i < 4; i++) begin
      apply(st[i], ev[i]);
      e = exp_q.pop_front();
      n_tests++;
      if (outs !== e) begin
        n_fail++;
        $display("FAIL jump_memstall[%0d] got=%b exp=%b", i, outs, e);
      end
    end
  endtask

  task automatic test_timeout();
    logic [20:0] st[6];
    logic [5:0]  ev[6];
    logic [20:0] ms;
    logic [5:0]  e;
    ms = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      st[i] = ms;
      ev[i] = O_MEM;
    end
    st[4] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1); ev[4] = O_ERR;
    st[5] = IDLE;                                                       ev[5] = O_ERR;
    for (int i = 0; i < 6; i++) begin
      apply(st[i], ev[i]);
      e = exp_q.pop_front();
      n_tests++;
      if (outs !== e) begin
        n_fail++;
        $display("FAIL timeout[%0d] got=%b exp=%b", i, outs, e);
      end
    end
    // Asynchronous reset mid-cycle, then release: error must be gone.
    #2;
    rst_i = 1'b0;
    exp_q.push_back(O_RST);
    #1;
    e = exp_q.pop_front();
    n_tests++;
    if (outs !== e) begin
      n_fail++;
      $display("FAIL timeout_async_rst got=%b exp=%b", outs, e);
    end
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    apply(IDLE, O_NORM);
    e = exp_q.pop_front();
    n_tests++;
    if (outs !== e) begin
      n_fail++;
      $display("FAIL timeout_after_rst got=%b exp=%b", outs, e);
    end
  endtask

  task automatic test_perf();
    logic [20:0] st[8];
    logic [31:0] exp_stall, exp_flush;
    logic [20:0] ms;
    ms = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();
    st[0] = mk(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    st[1] = ms;
    st[2] = ms;
    st[3] = ms;
    st[4] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    st[5] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    st[6] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    st[7] = IDLE;
`ifdef HAZARD_PERF_CNT_EN
    exp_stall = 32'd4;
    exp_flush = 32'd2;
`else
    exp_stall = 32'd0;
    exp_flush = 32'd0;
`endif
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      set_in(st[i]);
    end
    @(negedge clk);
    n_tests++;
    if (stall_cnt_o !== exp_stall) begin
      n_fail++;
      $display("FAIL perf_stall got=%0d exp=%0d", stall_cnt_o, exp_stall);
    end
    n_tests++;
    if (flush_cnt_o !== exp_flush) begin
      n_fail++;
      $display("FAIL perf_flush got=%0d exp=%0d", flush_cnt_o, exp_flush);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_back_to_back();
    test_jump_memstall();
    test_timeout();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It drives the stall, flush and bubble controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards, taken branches and jumps resolved in ID, and data-memory wait states, and it escalates a stuck memory access to a sticky error. It sits beside the decode stage and is the producer of the write-enable/flush interface that the pipeline registers receive.

## Interface
- MEM_TIMEOUT, 16: max consecutive data-memory wait cycles before error (1..255)
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-low
- ifid_rsaddr_i  input  5  rs field of instruction in ID
- ifid_rtaddr_i  input  5  rt field of instruction in ID
- ifid_uses_rt_i  input  1  ID instruction reads rt as a source (R-type, beq, sw)
- idex_memread_i  input  1  instruction in EX is a load
- idex_rtaddr_i  input  5  load destination in EX
- branch_taken_i  input  1  branch resolved taken in ID
- jump_i  input  1  jump decoded in ID
- exmem_memreq_i  input  1  MEM-stage instruction accesses data memory
- dmem_ack_i  input  1  data memory completes access this cycle
- pc_write_o  output  1  PC update enable
- ifid_write_o  output  1  IF/ID write enable
- ifid_flush_o  output  1  IF/ID load zeros (effective only with ifid_write_o=1)
- idex_bubble_o  output  1  zero all ID/EX control fields
- stall_all_o  output  1  hold PC, IF/ID, ID/EX, EX/MEM; MEM/WB loads a bubble
- mem_err_o  output  1  sticky memory timeout
- stall_cnt_o  output  32  stall-cycle count (perf)
- flush_cnt_o  output  32  flush count (perf)

## Operation
- FSM states: RUN, WAIT, ERR; reset state RUN; 8-bit wait counter wcnt, reset 0.
- memstall = exmem_memreq_i & ~dmem_ack_i.
- loaduse = idex_memread_i & (idex_rtaddr_i != 0) & ((idex_rtaddr_i == ifid_rsaddr_i) | (ifid_uses_rt_i & idex_rtaddr_i == ifid_rtaddr_i)).
- redirect = branch_taken_i | jump_i.
- Priority: ERR > memstall > loaduse > redirect.
- ERR: stall_all_o=1, pc_write_o=0, ifid_write_o=0, idex_bubble_o=0, mem_err_o=1; held until reset.
- memstall (RUN/WAIT): stall_all_o=1, pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=0.
- loaduse: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, flush 0. A branch depending on a load therefore stalls first and redirects one cycle later.
- redirect: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1, idex_bubble_o=0.
- Otherwise: pc_write_o=1, ifid_write_o=1, others 0.
- Transitions:
  - RUN→WAIT on memstall.
  - WAIT→RUN on dmem_ack_i.
  - WAIT→ERR when wcnt reaches MEM_TIMEOUT-1 with no ack.
  - wcnt increments in WAIT and clears on entry to RUN.
- Redirect deferred by memstall remains visible in ID and is taken once memstall drops; no separate latch.

## Timing
- Stall/flush/bubble outputs are combinational from inputs and current state; zero-cycle latency.
- State, wcnt and counters update on the rising edge of clk_i.
- While rst_i=0: pc_write_o=0, ifid_write_o=1, ifid_flush_o=1, idex_bubble_o=1, stall_all_o=0, mem_err_o=0, counters 0, state RUN, wcnt 0. IF/ID thus clears on the first edge after reset release only if flush is still decoded.
- Reset asserted mid-WAIT or in ERR returns to RUN immediately (async).
- Ack in the same cycle as the request: no stall, stays RUN.
- memstall lasting exactly MEM_TIMEOUT cycles: ERR entered on the edge ending cycle MEM_TIMEOUT; ack arriving in that cycle wins and the FSM goes to RUN.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt_o +1 each cycle with pc_write_o=0 (excluding reset).
  - flush_cnt_o +1 each cycle with ifid_flush_o=1 and rst_i=1.
  - Both counters wrap at 2^32.
- Undefined: both counters are constant 0 and no counter flops are built.

## Test plan
- Load-use: idex_memread_i=1, idex_rtaddr_i=8, ifid_rsaddr_i=8 -> pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 for 1 cycle; with rtaddr=0 -> no stall.
- Branch: branch_taken_i=1, no hazard -> ifid_flush_o=1, ifid_write_o=1, pc_write_o=1; with concurrent load-use on rs -> stall cycle first, flush next cycle.
- Memory wait: exmem_memreq_i=1, dmem_ack_i low 3 cycles then high -> stall_all_o=1 for 3 cycles, state WAIT→RUN, wcnt back to 0.
- Timeout: MEM_TIMEOUT=4, ack never -> mem_err_o=1 after 4th cycle, stall_all_o stuck 1; rst_i pulse low -> mem_err_o=0, RUN.
- Simultaneous memstall + jump_i -> no flush while stalled; flush asserted on cycle ack arrives.
- Perf (HAZARD_PERF_CNT_EN): 1 load-use + 3 wait cycles + 2 flushes -> stall_cnt_o=4, flush_cnt_o=2.
